// File: rtl/sr_cmd_debouncer_pkg.sv
// Shared types for the SR command debouncer: FSM states, command codes and
// default parameter values.
package sr_cmd_debouncer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    typedef enum logic {
        CMD_S = 1'b0,
        CMD_R = 1'b1
    } cmd_t;

    localparam int DB_CYCLES_DEF = 4;
    localparam int PULSE_LEN_DEF = 2;
    localparam int CNT_W_DEF     = 4;

endpackage

// File: rtl/sr_cmd_debouncer_debounce_cell.sv
// One button input path: 2-flop synchroniser, debounce counter and a registered
// rising-edge pulse on the debounced level.
module debounce_cell
    import sr_cmd_debouncer_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [1:0]       vld;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] arm_cnt;
    logic             armed;

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
    // so the synchroniser chain shifts by exactly one stage per clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            vld     <= 2'b00;
            cnt     <= '0;
            arm_cnt <= '0;
            armed   <= 1'b0;
            level   <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            vld   <= {vld[0], 1'b1};
            rise  <= 1'b0;

            if (sync2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                    rise  <= sync2 & armed;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end

            // A button held through reset must be seen released (debounced low
            // on valid samples) before its next press can issue a command.
            if (!armed) begin
                if (vld[1] && !sync2 && !level) begin
                    if (arm_cnt == CNT_LAST) begin
                        armed <= 1'b1;
                    end else begin
                        arm_cnt <= arm_cnt + 1'b1;
                    end
                end else begin
                    arm_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/sr_cmd_debouncer.sv
// Debounced set/reset command generator for a gated SR latch: arbitration of
// pending requests, DRIVE/GAP sequencing and registered s/r/en outputs.
module sr_cmd_debouncer
    import sr_cmd_debouncer_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int PULSE_LEN = PULSE_LEN_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_s,
    input  logic btn_r,
    output logic s,
    output logic r,
    output logic en,
    output logic busy,
    output logic conflict
);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);

    logic level_s, rise_s, level_r, rise_r;

    debounce_cell #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_s (
        .clk   (clk),
        .rst   (rst),
        .din   (btn_s),
        .level (level_s),
        .rise  (rise_s)
    );

    debounce_cell #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_r (
        .clk   (clk),
        .rst   (rst),
        .din   (btn_r),
        .level (level_r),
        .rise  (rise_r)
    );

    state_t           state, state_nx;
    cmd_t             cmd, cmd_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             pend_s, pend_r;
    logic             want_s, want_r;
    logic             grant_s, grant_r;

    // Simultaneous requests: r wins and the s request is discarded.
    assign want_r = pend_r | rise_r;
    assign want_s = pend_s | (rise_s & ~rise_r);

    // NOTE: every always_comb output gets a default first so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        cmd_nx   = cmd;
        cnt_nx   = cnt;
        grant_s  = 1'b0;
        grant_r  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (want_r) begin
                    state_nx = ST_DRIVE;
                    cmd_nx   = CMD_R;
                    cnt_nx   = PULSE_LOAD;
                    grant_r  = 1'b1;
                end else if (want_s) begin
                    state_nx = ST_DRIVE;
                    cmd_nx   = CMD_S;
                    cnt_nx   = PULSE_LOAD;
                    grant_s  = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (cnt == '0) begin
                    state_nx = ST_GAP;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            ST_GAP:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // NOTE: the async reset clears the output flops directly, so s/r/en drop
    // the moment rst falls rather than at the next clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cmd      <= CMD_S;
            cnt      <= '0;
            pend_s   <= 1'b0;
            pend_r   <= 1'b0;
            s        <= 1'b0;
            r        <= 1'b0;
            en       <= 1'b0;
            conflict <= 1'b0;
        end else begin
            state    <= state_nx;
            cmd      <= cmd_nx;
            cnt      <= cnt_nx;
            pend_s   <= want_s & ~grant_s;
            pend_r   <= want_r & ~grant_r;
            en       <= (state_nx == ST_DRIVE);
            s        <= (state_nx == ST_DRIVE) && (cmd_nx == CMD_S);
            r        <= (state_nx == ST_DRIVE) && (cmd_nx == CMD_R);
            conflict <= rise_s & rise_r;
        end
    end

    assign busy = (state != ST_IDLE);

    a_no_sr:     assert property (@(posedge clk) disable iff (!rst) !(s && r));
    a_en_drive:  assert property (@(posedge clk) disable iff (!rst) en == (state == ST_DRIVE));
    a_rise_s_lv: assert property (@(posedge clk) disable iff (!rst) rise_s |-> level_s);
    a_rise_r_lv: assert property (@(posedge clk) disable iff (!rst) rise_r |-> level_r);

endmodule

// File: tb/tb_sr_cmd_debouncer.sv
// Scoreboard bench for sr_cmd_debouncer: expected pulses are queued at stimulus
// time and matched against pulses reconstructed from the outputs.
module tb_sr_cmd_debouncer;

    localparam int DB  = 4;
    localparam int PL  = 2;
    localparam int LAT = DB + 2;

    typedef struct {
        logic is_r;
        int   len;
        int   start;
    } pulse_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_s = 1'b0;
    logic btn_r = 1'b0;
    logic s, r, en, busy, conflict;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    pulse_t exp_q[$];
    pulse_t obs_q[$];

    logic in_p = 1'b0;
    logic p_r  = 1'b0;
    int   p_len;
    int   p_start;

    sr_cmd_debouncer #(.DB_CYCLES(DB), .PULSE_LEN(PL), .CNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_s    (btn_s),
        .btn_r    (btn_r),
        .s        (s),
        .r        (r),
        .en       (en),
        .busy     (busy),
        .conflict (conflict)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Pulse reconstruction and per-cycle invariants.
    always @(negedge clk) begin
        if (en === 1'b1) begin
            if (!in_p) begin
                in_p    = 1'b1;
                p_len   = 0;
                p_start = cyc;
                p_r     = r;
            end
            p_len++;
        end else if (in_p) begin
            in_p = 1'b0;
            obs_q.push_back('{p_r, p_len, p_start});
        end
        n_checks++;
        if ((s & r) !== 1'b0 || en !== (s | r)) begin
            n_fail++;
            $display("FAIL invariant at cycle %0d: s=%b r=%b en=%b (need s&r=0, en==s|r)", cyc, s, r, en);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic push_exp(input logic is_r, input int len, input int start);
        exp_q.push_back('{is_r, len, start});
    endtask

    task automatic drain(input string tag);
        pulse_t e, o;
        int t;
        while (exp_q.size() > 0) begin
            t = 0;
            while (obs_q.size() == 0 && t < 60) begin
                @(negedge clk);
                t++;
            end
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s pulse timeout: got none, expected is_r=%b len=%0d start=%0d", tag, e.is_r, e.len, e.start);
            end else begin
                o = obs_q.pop_front();
                if (o.is_r !== e.is_r || o.len != e.len || o.start != e.start) begin
                    n_fail++;
                    $display("FAIL %s pulse: got is_r=%b len=%0d start=%0d, expected is_r=%b len=%0d start=%0d",
                             tag, o.is_r, o.len, o.start, e.is_r, e.len, e.start);
                end
            end
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s extra pulses: got %0d, expected 0", tag, obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            btn_s = i[0];
            btn_r = i[1];
            #2;
            n_checks++;
            if ({s, r, en, busy, conflict} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_hold: got s,r,en,busy,conflict=%b, expected 00000", {s, r, en, busy, conflict});
            end
        end
        @(negedge clk);
        btn_s = 1'b0;
        btn_r = 1'b0;
        rst   = 1'b1;
        repeat (12) begin
            @(negedge clk);
            n_checks++;
            if ({s, r, en, busy, conflict} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_release: got s,r,en,busy,conflict=%b, expected 00000", {s, r, en, busy, conflict});
            end
        end
        drain("reset");
    endtask

    task automatic test_single_set();
        int n0;
        @(negedge clk);
        btn_s = 1'b1;
        n0 = cyc + 1;
        push_exp(1'b0, PL, n0 + LAT);
        repeat (20) begin
            @(negedge clk);
            if (cyc == n0 + LAT + 1) begin
                n_checks++;
                if ({busy, en, s} !== 3'b111) begin
                    n_fail++;
                    $display("FAIL set_drive: got busy,en,s=%b, expected 111", {busy, en, s});
                end
            end
            if (cyc == n0 + LAT + PL) begin
                n_checks++;
                if ({busy, en} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL set_gap: got busy,en=%b, expected 10", {busy, en});
                end
            end
            if (cyc == n0 + LAT + PL + 1) begin
                n_checks++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL set_idle: got busy=%b, expected 0", busy);
                end
            end
        end
        btn_s = 1'b0;
        repeat (10) @(negedge clk);
        drain("single_set");
    endtask

    task automatic test_bounce();
        int en_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            btn_s = ~btn_s;
            @(negedge clk);
            if (en !== 1'b0) en_cycles++;
        end
        @(negedge clk);
        btn_s = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (en !== 1'b0) en_cycles++;
        end
        n_checks++;
        if (en_cycles != 0) begin
            n_fail++;
            $display("FAIL bounce: got %0d en cycles, expected 0", en_cycles);
        end
        drain("bounce");
    endtask

    task automatic test_conflict();
        int n0;
        int c_cnt = 0;
        int c_cyc = -1;
        int s_cnt = 0;
        @(negedge clk);
        btn_s = 1'b1;
        btn_r = 1'b1;
        n0 = cyc + 1;
        push_exp(1'b1, PL, n0 + LAT);
        repeat (20) begin
            @(negedge clk);
            if (conflict === 1'b1) begin
                c_cnt++;
                c_cyc = cyc;
            end
            if (s !== 1'b0) s_cnt++;
        end
        n_checks++;
        if (c_cnt != 1 || c_cyc != n0 + LAT) begin
            n_fail++;
            $display("FAIL conflict_pulse: got %0d cycles (last at %0d), expected 1 at %0d", c_cnt, c_cyc, n0 + LAT);
        end
        n_checks++;
        if (s_cnt != 0) begin
            n_fail++;
            $display("FAIL conflict_no_s: got %0d s cycles, expected 0", s_cnt);
        end
        btn_s = 1'b0;
        btn_r = 1'b0;
        repeat (10) @(negedge clk);
        drain("conflict");
    endtask

    task automatic test_back_to_back();
        int n0;
        @(negedge clk);
        btn_s = 1'b1;
        n0 = cyc + 1;
        @(negedge clk);
        btn_r = 1'b1;
        // r rises one cycle later, so its request lands while S is in DRIVE;
        // it is granted after GAP and the following IDLE cycle.
        push_exp(1'b0, PL, n0 + LAT);
        push_exp(1'b1, PL, n0 + LAT + PL + 2);
        repeat (25) begin
            @(negedge clk);
            if (cyc == n0 + LAT + PL) begin
                n_checks++;
                if ({busy, en} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL b2b_gap: got busy,en=%b, expected 10", {busy, en});
                end
            end
        end
        btn_s = 1'b0;
        btn_r = 1'b0;
        repeat (10) @(negedge clk);
        drain("back_to_back");
    endtask

    task automatic test_reset_mid_drive();
        int n0;
        int t = 0;
        @(negedge clk);
        btn_s = 1'b1;
        n0 = cyc + 1;
        push_exp(1'b0, 1, n0 + LAT);
        while (cyc < n0 + LAT && t < 40) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (en !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_drive_pre: got en=%b, expected 1", en);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({s, r, en, busy} !== 4'b0) begin
            n_fail++;
            $display("FAIL mid_drive_async: got s,r,en,busy=%b, expected 0000", {s, r, en, busy});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        drain("reset_held");
        btn_s = 1'b0;
        repeat (16) @(negedge clk);
        btn_s = 1'b1;
        n0 = cyc + 1;
        push_exp(1'b0, PL, n0 + LAT);
        repeat (15) @(negedge clk);
        btn_s = 1'b0;
        repeat (10) @(negedge clk);
        drain("repress");
    endtask

    initial begin
        test_reset();
        test_single_set();
        test_bounce();
        test_conflict();
        test_back_to_back();
        test_reset_mid_drive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
